ray_color_writer: RTL and testbench
===================================

RAY_COLOR_WRITER -- requirements
Module: ray_color_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 1280: frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720: frame height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries, a power of two.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port color_valid  input  1  one-cycle strobe from the tracer: the pixel inputs are valid.
REQ-007 SHALL have port pixel_color  input  72 (fp24_vec3)  {r,g,b}; r in [71:48], g in [47:24], b in [23:0].
REQ-008 SHALL have port pixel_h_in  input  11  pixel column.
REQ-009 SHALL have port pixel_v_in  input  10  pixel row.
REQ-010 SHALL have port fb_addr  output  $clog2(WIDTH*HEIGHT)  framebuffer word address (20 bits at the defaults).
REQ-011 SHALL have port fb_data  output  16  RGB565 pixel.
REQ-012 SHALL have port fb_valid  output  1  FIFO head holds a write.
REQ-013 SHALL have port fb_ready  input  1  the framebuffer accepts a write this cycle.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-015 SHALL have port overflow  output  1  sticky flag: an input was dropped.

Function
REQ-016 SHALL take the tracer output without back-pressure; color_valid is never stalled.
REQ-017 SHALL decode fp24 as sign [23], exponent [22:16] with bias 63, and mantissa [15:0] with an implicit leading 1.
REQ-018 SHALL convert each channel to an 8-bit value c8 as follows:
- sign=1 or exponent=0 -> 0.
- exponent>=63 -> 255.
- otherwise c8 = {1,mantissa} >> (71-exponent), truncated; a shift of 17 or more gives 0.
REQ-019 SHALL pack fb_data = {r8[7:3], g8[7:2], b8[7:3]}.
REQ-020 SHALL compute address = pixel_v_in*WIDTH + pixel_h_in; out-of-range coordinates are not checked.
REQ-021 SHALL be a two-stage datapath:
- Stage 1: the color_valid edge registers c8 conversion, packing and address.
- Stage 2: the next edge pushes that result into the FIFO.
REQ-022 SHALL give a latency of 2 cycles from a color_valid edge to fb_valid=1 when the FIFO was empty; fb_addr and fb_data always show the FIFO head.
REQ-023 SHALL transfer a write on any cycle with fb_valid&&fb_ready; the pop takes effect at that edge.
REQ-024 SHALL keep fb_valid = FIFO not empty; fb_valid does not depend on fb_ready.
REQ-025 SHALL accept a simultaneous push and pop when the FIFO is full; count is unchanged and no drop occurs.
REQ-026 SHALL drop the stage-1 entry when the FIFO is full and no pop occurs that cycle; FIFO contents are unchanged and overflow is set to 1.
REQ-027 SHALL hold overflow until reset.
REQ-028 SHALL use wrapping read/write pointers modulo FIFO_DEPTH and a count from 0 to FIFO_DEPTH.
REQ-029 SHALL pulse frame_done for exactly one cycle, on the cycle after a transfer whose fb_addr = WIDTH*HEIGHT-1.
REQ-030 SHALL preserve FIFO order: writes leave in arrival order.

Reset
REQ-031 SHALL, on any cycle with rst=1, clear the stage-1 valid, empty the FIFO and drive fb_valid=0, frame_done=0 and overflow=0 from the next edge.
REQ-032 SHALL discard in-flight entries when reset is asserted mid-operation; no write is issued for them after rst falls.
REQ-033 SHALL ignore color_valid on cycles where rst=1.
REQ-034 SHALL show don't-care fb_addr/fb_data while fb_valid=0.

Verification
REQ-035 Basic path: color {0x3F0000,0x3E0000,0x000000} at h=3, v=2 -> 2 cycles later fb_valid=1, fb_addr=2563, fb_data=0xFC00.
REQ-036 Conversion corners: channels 0xBF0000 -> 0; 0x410000 -> 255; 0x3E8000 -> 192; 0x300000 -> 0 (shift>=17).
REQ-037 Overflow: fb_ready=0, 9 back-to-back inputs -> 8 held, overflow=1, fb_valid=1; then fb_ready=1 -> 8 writes in order, 9th absent.
REQ-038 Full boundary: FIFO full with fb_ready=1 and color_valid each cycle -> no drop, overflow stays 0.
REQ-039 Frame end: h=1279, v=719 transferred -> fb_addr=921599, frame_done=1 for exactly the next cycle.
REQ-040 Mid-operation reset: 3 queued entries, rst pulsed for 1 cycle -> fb_valid=0 after the edge, overflow=0, no stale writes.

Source files
------------

// File: rtl/ray_color_writer.sv
// ray_color_writer: converts traced fp24 RGB pixels to RGB565, computes the
// framebuffer word address and queues the write in a small FIFO that drains
// under fb_ready handshaking. The tracer side is never stalled; a write that
// finds the FIFO full with no pop in the same cycle is dropped and flagged.
module ray_color_writer #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 color_valid,
    input  logic [71:0]                          pixel_color,
    input  logic [10:0]                          pixel_h_in,
    input  logic [9:0]                           pixel_v_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]      fb_addr,
    output logic [15:0]                          fb_data,
    output logic                                 fb_valid,
    input  logic                                 fb_ready,
    output logic                                 frame_done,
    output logic                                 overflow
);

    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 16;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    // fp24 channel -> 8-bit intensity. Negative or zero-exponent values clamp
    // to black, values >= 1.0 saturate, the rest are a truncating right shift
    // of the 17-bit significand so that 1.0 (exp 63) would land on 256.
    function automatic logic [7:0] fp24_to_c8(input logic [23:0] f);
        logic [6:0]  exp_f;
        logic [16:0] mant;
        logic [6:0]  shamt;
        logic [7:0]  c8;
        exp_f = f[22:16];
        mant  = {1'b1, f[15:0]};
        shamt = 7'd71 - exp_f;
        if (f[23] || exp_f == 7'd0) begin
            c8 = 8'd0;
        end else if (exp_f >= 7'd63) begin
            c8 = 8'hFF;
        end else if (shamt >= 7'd17) begin
            c8 = 8'd0;
        end else begin
            c8 = 8'(mant >> shamt);
        end
        return c8;
    endfunction

    logic [7:0]    w_r8;
    logic [7:0]    w_g8;
    logic [7:0]    w_b8;
    logic [15:0]   w_pix565;
    logic [AW-1:0] w_addr;

    assign w_r8     = fp24_to_c8(pixel_color[71:48]);
    assign w_g8     = fp24_to_c8(pixel_color[47:24]);
    assign w_b8     = fp24_to_c8(pixel_color[23:0]);
    assign w_pix565 = {w_r8[7:3], w_g8[7:2], w_b8[7:3]};
    assign w_addr   = AW'(int'(pixel_v_in) * WIDTH + int'(pixel_h_in));

    logic          r_s1_valid;
    logic [AW-1:0] r_s1_addr;
    logic [15:0]   r_s1_data;

    // Stage 1: capture the converted pixel and its address on the strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= color_valid;
        end
        if (color_valid) begin
            r_s1_addr <= w_addr;
            r_s1_data <= w_pix565;
        end
    end

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_frame_done;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_head;

    assign fb_valid = (r_count != '0);
    assign w_full   = (r_count == FULL_COUNT);
    assign w_pop    = fb_valid && fb_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_push   = r_s1_valid && (!w_full || w_pop);
    assign w_drop   = r_s1_valid && w_full && !w_pop;

    assign w_head     = r_mem[r_rptr];
    assign fb_addr    = w_head[EW-1:16];
    assign fb_data    = w_head[15:0];
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;

    // Stage 2: write the stage-1 result into the FIFO storage.
    // NOTE: the storage array has no reset; occupancy is tracked by the reset
    // pointers and count, so stale words are never visible as valid writes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_s1_addr, r_s1_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // One-cycle pulse following the transfer of the frame's final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && (fb_addr == LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_ray_color_writer.sv
// Self-checking bench for ray_color_writer: table-driven conversion/address
// vectors followed by hand-written overflow, full-boundary, frame-end and
// mid-operation reset sequences. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_ray_color_writer;

    logic        clk;
    logic        rst;
    logic        color_valid;
    logic [71:0] pixel_color;
    logic [10:0] pixel_h_in;
    logic [9:0]  pixel_v_in;
    logic [19:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_valid;
    logic        fb_ready;
    logic        frame_done;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    ray_color_writer dut (
        .clk         (clk),
        .rst         (rst),
        .color_valid (color_valid),
        .pixel_color (pixel_color),
        .pixel_h_in  (pixel_h_in),
        .pixel_v_in  (pixel_v_in),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] color;
        logic [10:0] h;
        logic [9:0]  v;
        logic [19:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Watchdog so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    localparam logic [71:0] GREY = {24'h3E0000, 24'h3E0000, 24'h3E0000};

    initial begin
        // Hand-computed vectors: r8/g8/b8 derived from the fp24 rules, then packed.
        vecs[0] = '{{24'h3F0000, 24'h3E0000, 24'h000000}, 11'd3,    10'd2,   20'd2563,   16'hFC00};
        vecs[1] = '{{24'hBF0000, 24'h410000, 24'h3E8000}, 11'd0,    10'd0,   20'd0,      16'h07F8};
        vecs[2] = '{{24'h300000, 24'h3E8000, 24'h410000}, 11'd1279, 10'd0,   20'd1279,   16'h061F};
        vecs[3] = '{{24'h3D0000, 24'h3DFFFF, 24'h3C0000}, 11'd5,    10'd1,   20'd1285,   16'h43E4};
        vecs[4] = '{GREY,                                 11'd0,    10'd719, 20'd920320, 16'h8410};
        vecs[5] = '{{24'hC10000, 24'h000001, 24'h3F0000}, 11'd100,  10'd300, 20'd384100, 16'h001F};

        rst         = 1'b1;
        color_valid = 1'b0;
        pixel_color = '0;
        pixel_h_in  = '0;
        pixel_v_in  = '0;
        fb_ready    = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset fb_valid", 32'(fb_valid), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors: one pixel each, checked at the FIFO head, then popped.
        for (int i = 0; i < 6; i++) begin
            color_valid = 1'b1;
            pixel_color = vecs[i].color;
            pixel_h_in  = vecs[i].h;
            pixel_v_in  = vecs[i].v;
            @(negedge clk);
            color_valid = 1'b0;
            check($sformatf("vec%0d fb_valid after 1 cycle", i), 32'(fb_valid), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d fb_valid after 2 cycles", i), 32'(fb_valid), 32'd1);
            check($sformatf("vec%0d fb_addr", i), 32'(fb_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d fb_data", i), 32'(fb_data), 32'(vecs[i].data));
            fb_ready = 1'b1;
            @(negedge clk);
            fb_ready = 1'b0;
            check($sformatf("vec%0d fb_valid after pop", i), 32'(fb_valid), 32'd0);
            check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'd0);
        end

        // Frame end: last pixel transferred -> one-cycle frame_done.
        color_valid = 1'b1;
        pixel_color = GREY;
        pixel_h_in  = 11'd1279;
        pixel_v_in  = 10'd719;
        @(negedge clk);
        color_valid = 1'b0;
        @(negedge clk);
        check("frame fb_valid", 32'(fb_valid), 32'd1);
        check("frame fb_addr", 32'(fb_addr), 32'd921599);
        check("frame_done before transfer", 32'(frame_done), 32'd0);
        fb_ready = 1'b1;
        @(negedge clk);
        fb_ready = 1'b0;
        check("frame_done after transfer", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("frame_done second cycle", 32'(frame_done), 32'd0);

        // Overflow: 9 back-to-back inputs with no drain; the 9th is dropped.
        fb_ready    = 1'b0;
        pixel_color = GREY;
        pixel_v_in  = 10'd0;
        for (int k = 0; k < 11; k++) begin
            color_valid = (k < 9);
            pixel_h_in  = 11'(k);
            @(negedge clk);
        end
        check("ovf overflow set", 32'(overflow), 32'd1);
        check("ovf fb_valid", 32'(fb_valid), 32'd1);
        fb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf drain%0d fb_valid", k), 32'(fb_valid), 32'd1);
            check($sformatf("ovf drain%0d fb_addr", k), 32'(fb_addr), 32'(k));
            @(negedge clk);
        end
        check("ovf 9th absent", 32'(fb_valid), 32'd0);
        check("ovf sticky", 32'(overflow), 32'd1);
        fb_ready = 1'b0;

        // Mid-operation reset: 3 queued entries plus a strobe during reset.
        for (int k = 0; k < 5; k++) begin
            color_valid = (k < 3);
            pixel_h_in  = 11'(50 + k);
            @(negedge clk);
        end
        check("midrst queued fb_valid", 32'(fb_valid), 32'd1);
        check("midrst queued head", 32'(fb_addr), 32'd50);
        rst         = 1'b1;
        color_valid = 1'b1;
        pixel_h_in  = 11'd77;
        @(negedge clk);
        rst         = 1'b0;
        color_valid = 1'b0;
        check("midrst fb_valid", 32'(fb_valid), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        check("midrst frame_done", 32'(frame_done), 32'd0);
        fb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("midrst no stale write %0d", k), 32'(fb_valid), 32'd0);
        end
        fb_ready = 1'b0;

        // Full boundary: fill to 8 with stage 1 also loaded, then drain while
        // still pushing every cycle; each push meets a full FIFO with a pop.
        for (int k = 0; k < 24; k++) begin
            color_valid = (k < 14);
            pixel_h_in  = 11'(k);
            fb_ready    = (k >= 9);
            if (k >= 9 && k < 23) begin
                check($sformatf("full k%0d fb_valid", k), 32'(fb_valid), 32'd1);
                check($sformatf("full k%0d fb_addr", k), 32'(fb_addr), 32'(k - 9));
            end else if (k == 23) begin
                check("full drained", 32'(fb_valid), 32'd0);
            end
            @(negedge clk);
        end
        check("full overflow stays 0", 32'(overflow), 32'd0);
        fb_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
